// File: rtl/scratch_fill_controller_if.sv
// Stream, write-port and status bundle for scratch_fill_controller.
// The master side drives commands and data; the slave side is the controller.
interface scratch_fill_controller_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH) + 1
) ();
    logic              i_start;
    logic [LEN_W-1:0]  i_len;
    logic              i_scratch_write_en;
    logic              i_in_valid;
    logic [DATA_W-1:0] i_in_data;
    logic              o_in_ready;
    logic              i_release;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_cnt;
    logic [LEN_W-1:0]  o_count;
    logic              o_full;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_start, i_len, i_scratch_write_en, i_in_valid, i_in_data, i_release,
        input  o_in_ready, o_wr_en, o_wr_addr, o_wr_data, o_cnt, o_count, o_full, o_busy, o_done
    );

    modport slave (
        input  i_start, i_len, i_scratch_write_en, i_in_valid, i_in_data, i_release,
        output o_in_ready, o_wr_en, o_wr_addr, o_wr_data, o_cnt, o_count, o_full, o_busy, o_done
    );
endinterface

// File: rtl/scratch_fill_controller.sv
// Fills a circular scratchpad from a valid/ready stream in bursts of a commanded
// length and tracks how many entries are occupied until the consumer releases them.
module scratch_fill_controller #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH) + 1
) (
    input logic                      clk,
    input logic                      rst,
    scratch_fill_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  w_remaining_nxt;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  w_count_nxt;
    logic [LEN_W-1:0]  w_len_clamped;
    logic [ADDR_W-1:0] r_wptr;
    logic              w_full;
    logic              w_ready;
    logic              w_hs;
    logic              w_rel_ok;

    assign w_len_clamped = (bus.i_len > DEPTH_L) ? DEPTH_L : bus.i_len;
    assign w_full        = (r_count == DEPTH_L);
    assign w_ready       = (r_state == ST_FILL) & bus.i_scratch_write_en & ~w_full;
    assign w_hs          = bus.i_in_valid & w_ready;
    // A release with nothing stored is dropped so the count cannot underflow.
    assign w_rel_ok      = bus.i_release & (r_count != {LEN_W{1'b0}});

    // Burst sequencing: next state and words still owed in the current burst
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_remaining_nxt = w_len_clamped;
                    if (w_len_clamped == {LEN_W{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_hs) begin
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Occupancy update: a write and an honoured release in one cycle cancel out
    always_comb begin
        w_count_nxt = r_count;
        if (w_hs && !w_rel_ok) begin
            w_count_nxt = r_count + LEN_W'(1);
        end else if (!w_hs && w_rel_ok) begin
            w_count_nxt = r_count - LEN_W'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // State, burst length, write pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= {LEN_W{1'b0}};
            r_count     <= {LEN_W{1'b0}};
            r_wptr      <= {ADDR_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_count     <= w_count_nxt;
            // DEPTH is a power of two, so the natural overflow is the ring wrap.
            if (w_hs) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end else begin
                r_wptr <= r_wptr;
            end
        end
    end

    assign bus.o_in_ready = w_ready;
    assign bus.o_wr_en    = w_hs;
    assign bus.o_cnt      = w_hs;
    assign bus.o_wr_addr  = r_wptr;
    assign bus.o_wr_data  = bus.i_in_data;
    assign bus.o_count    = r_count;
    assign bus.o_full     = w_full;
    assign bus.o_busy     = (r_state == ST_FILL);
    assign bus.o_done     = (r_state == ST_DONE);
endmodule
